// File: rtl/iram_loader_pkg.sv
// Shared definitions for the monitor-side i-RAM loader.
package iram_loader_pkg;

    // Default i-RAM word-address width; must track the fetch stage.
    localparam int IWIDTH_DEF = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_RADR  = 3'd3,
        S_RDATA = 3'd4,
        S_RSEND = 3'd5,
        S_RUN   = 3'd6
    } state_t;

endpackage

// File: rtl/iram_loader_byte_packer.sv
// Packs up to four bytes into a little-endian 32-bit word.
// word is the merged value including the byte accepted this cycle, so it
// holds the complete word in the same cycle that word_rdy is high.
module iram_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_rdy,
    output logic [31:0] word
);

    logic [1:0]  bcnt;
    logic [31:0] word_q;
    logic [31:0] merged;

    // Drop the incoming byte into the lane selected by the byte counter
    always_comb begin
        merged = word_q;
        case (bcnt)
            2'd0: merged[7:0]   = byte_in;
            2'd1: merged[15:8]  = byte_in;
            2'd2: merged[23:16] = byte_in;
            2'd3: merged[31:24] = byte_in;
            default: merged = word_q;
        endcase
    end

    assign word     = merged;
    assign word_rdy = accept && (bcnt == 2'd3);

    // Lane counter and pack register; counter wraps to lane 0 after a full word
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bcnt   <= 2'd0;
            word_q <= 32'd0;
        end else if (accept) begin
            word_q <= merged;
            bcnt   <= bcnt + 2'd1;
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Monitor-side i-RAM master: byte-stream load, word dump, CPU launch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for ld_start / rd_start / run_req
// S_LOAD  | collecting bytes into the packer
// S_WRITE | one-cycle i-RAM write of the packed word
// S_RADR  | monitor read address presented to i-RAM
// S_RDATA | capture i-RAM read data into out_word
// S_RSEND | hold out_vld until the consumer takes the word
// S_RUN   | one-cycle pc_start pulse
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int IWIDTH = IWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [IWIDTH-1:0] ld_adr,
    input  logic [IWIDTH:0]   ld_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_vld,
    input  logic              rd_start,
    input  logic [IWIDTH-1:0] rd_adr,
    input  logic [IWIDTH:0]   rd_len,
    output logic [31:0]       out_word,
    output logic              out_vld,
    input  logic              out_rdy,
    input  logic              run_req,
    input  logic [29:0]       run_adr,
    output logic [IWIDTH-1:0] i_ram_wadr,
    output logic [31:0]       i_ram_wdata,
    output logic              i_ram_wen,
    output logic [IWIDTH-1:0] i_ram_radr,
    input  logic [31:0]       i_ram_rdata,
    output logic              i_read_sel,
    output logic              pc_start,
    output logic [29:0]       start_adr,
    output logic              busy,
    output logic              done,
    output logic              byte_err
);

    localparam logic [IWIDTH:0]   CNT_ONE = (IWIDTH + 1)'(1);
    localparam logic [IWIDTH-1:0] ADR_ONE = IWIDTH'(1);

    state_t            state;
    logic [IWIDTH-1:0] adr;
    logic [IWIDTH:0]   wcnt;

    logic        pk_clear;
    logic        pk_accept;
    logic        pk_word_rdy;
    logic [31:0] pk_word;

    // A byte arriving in WRITE belongs to the next word, so it is accepted too
    assign pk_accept = byte_vld && ((state == S_LOAD) || (state == S_WRITE));
    assign pk_clear  = (state == S_IDLE) && ld_start;

    iram_loader_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pk_clear),
        .accept   (pk_accept),
        .byte_in  (byte_in),
        .word_rdy (pk_word_rdy),
        .word     (pk_word)
    );

    // Main sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            adr         <= '0;
            wcnt        <= '0;
            out_word    <= 32'd0;
            out_vld     <= 1'b0;
            i_ram_wadr  <= '0;
            i_ram_wdata <= 32'd0;
            i_ram_wen   <= 1'b0;
            i_ram_radr  <= '0;
            i_read_sel  <= 1'b0;
            pc_start    <= 1'b0;
            start_adr   <= 30'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_err    <= 1'b0;
        end else begin
            done      <= 1'b0;
            i_ram_wen <= 1'b0;
            pc_start  <= 1'b0;

            if (pk_clear) begin
                byte_err <= 1'b0;
            end else if (byte_vld && !pk_accept) begin
                byte_err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (ld_start) begin
                        if (ld_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            adr   <= ld_adr;
                            wcnt  <= ld_len;
                            busy  <= 1'b1;
                            state <= S_LOAD;
                        end
                    end else if (rd_start) begin
                        if (rd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            adr        <= rd_adr;
                            wcnt       <= rd_len;
                            i_ram_radr <= rd_adr;
                            i_read_sel <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_RADR;
                        end
                    end else if (run_req) begin
                        start_adr <= run_adr;
                        pc_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end

                S_LOAD: begin
                    if (pk_word_rdy) begin
                        i_ram_wen   <= 1'b1;
                        i_ram_wadr  <= adr;
                        i_ram_wdata <= pk_word;
                        state       <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    adr  <= adr + ADR_ONE;
                    wcnt <= wcnt - CNT_ONE;
                    if (wcnt == CNT_ONE) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_LOAD;
                    end
                end

                S_RADR: begin
                    state <= S_RDATA;
                end

                S_RDATA: begin
                    out_word <= i_ram_rdata;
                    out_vld  <= 1'b1;
                    state    <= S_RSEND;
                end

                S_RSEND: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        adr     <= adr + ADR_ONE;
                        wcnt    <= wcnt - CNT_ONE;
                        if (wcnt == CNT_ONE) begin
                            i_read_sel <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            i_ram_radr <= adr + ADR_ONE;
                            state      <= S_RADR;
                        end
                    end
                end

                S_RUN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    i_read_sel <= 1'b0;
                    out_vld    <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Directed self-checking bench for iram_loader with a behavioural i-RAM.
module tb_iram_loader;

    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start;
    logic [IW-1:0] ld_adr;
    logic [IW:0]   ld_len;
    logic [7:0]    byte_in;
    logic          byte_vld;
    logic          rd_start;
    logic [IW-1:0] rd_adr;
    logic [IW:0]   rd_len;
    logic [31:0]   out_word;
    logic          out_vld;
    logic          out_rdy;
    logic          run_req;
    logic [29:0]   run_adr;
    logic [IW-1:0] i_ram_wadr;
    logic [31:0]   i_ram_wdata;
    logic          i_ram_wen;
    logic [IW-1:0] i_ram_radr;
    logic [31:0]   i_ram_rdata;
    logic          i_read_sel;
    logic          pc_start;
    logic [29:0]   start_adr;
    logic          busy;
    logic          done;
    logic          byte_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iram_loader #(.IWIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_adr(ld_adr), .ld_len(ld_len),
        .byte_in(byte_in), .byte_vld(byte_vld),
        .rd_start(rd_start), .rd_adr(rd_adr), .rd_len(rd_len),
        .out_word(out_word), .out_vld(out_vld), .out_rdy(out_rdy),
        .run_req(run_req), .run_adr(run_adr),
        .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
        .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata), .i_read_sel(i_read_sel),
        .pc_start(pc_start), .start_adr(start_adr),
        .busy(busy), .done(done), .byte_err(byte_err)
    );

    // i-RAM model with one-cycle registered read, plus event logging
    logic [31:0] mem [0:(1<<IW)-1];
    logic [IW-1:0] wlog_adr [$];
    logic [31:0]   wlog_dat [$];
    int done_cnt = 0;
    int pc_cnt   = 0;
    int sel_cnt  = 0;
    int viol     = 0;

    always @(posedge clk) begin
        if (i_ram_wen) begin
            mem[i_ram_wadr] <= i_ram_wdata;
            wlog_adr.push_back(i_ram_wadr);
            wlog_dat.push_back(i_ram_wdata);
        end
        i_ram_rdata <= mem[i_ram_radr];
        if (done)       done_cnt++;
        if (pc_start)   pc_cnt++;
        if (i_read_sel) sel_cnt++;
        if (i_ram_wen && (pc_start || i_read_sel)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in  = b;
        byte_vld = 1'b1;
        tick();
        byte_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_vld(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_vld) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic start_load(input logic [IW-1:0] a, input logic [IW:0] n);
        ld_adr   = a;
        ld_len   = n;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        int w0, d0, s0, p0;
        logic [7:0] prog [8];
        logic [7:0] wrap [8];
        logic [7:0] tail [4];
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wrap = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tail = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        rst = 1'b1; ld_start = 0; ld_adr = '0; ld_len = '0; byte_in = '0; byte_vld = 0;
        rd_start = 0; rd_adr = '0; rd_len = '0; out_rdy = 0; run_req = 0; run_adr = '0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_outs", {out_vld, i_ram_wen, i_read_sel, pc_start, done, byte_err}, 0);
        chk("rst_word", out_word, 0);
        chk("rst_start_adr", start_adr, 0);

        // two-word load with a byte landing in the WRITE cycle
        w0 = wlog_adr.size(); d0 = done_cnt;
        start_load(12'h010, 13'd2);
        chk("ld_busy", busy, 1);
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        wait_done("ld_done");
        tick();
        chk("ld_nwrites", wlog_adr.size() - w0, 2);
        if (wlog_adr.size() - w0 == 2) begin
            chk("ld_adr0", wlog_adr[w0], 32'h010);
            chk("ld_dat0", wlog_dat[w0], 32'h0000_0013);
            chk("ld_adr1", wlog_adr[w0+1], 32'h011);
            chk("ld_dat1", wlog_dat[w0+1], 32'h0010_0093);
        end
        chk("ld_done_cnt", done_cnt - d0, 1);
        chk("ld_busy_low", busy, 0);
        chk("ld_no_err", byte_err, 0);

        // address wrap
        w0 = wlog_adr.size();
        start_load(12'hFFF, 13'd2);
        for (int i = 0; i < 8; i++) send_byte(wrap[i]);
        wait_done("wr_done");
        tick();
        chk("wr_nwrites", wlog_adr.size() - w0, 2);
        if (wlog_adr.size() - w0 == 2) begin
            chk("wr_adr0", wlog_adr[w0], 32'hFFF);
            chk("wr_dat0", wlog_dat[w0], 32'h4433_2211);
            chk("wr_adr1", wlog_adr[w0+1], 32'h000);
            chk("wr_dat1", wlog_dat[w0+1], 32'h8877_6655);
        end
        chk("sel_during_load", sel_cnt, 0);

        // dump with back-pressure
        d0 = done_cnt;
        rd_adr = 12'h010; rd_len = 13'd2; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("rd_sel", i_read_sel, 1);
        wait_vld("rd_vld0");
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_vld", out_vld, 1);
            chk("rd_hold_word", out_word, 32'h0000_0013);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        chk("rd_vld_drop", out_vld, 0);
        chk("rd_sel_mid", i_read_sel, 1);
        wait_vld("rd_vld1");
        chk("rd_word1", out_word, 32'h0010_0093);
        tick();
        out_rdy = 1'b0;
        wait_done("rd_done");
        tick();
        chk("rd_sel_off", i_read_sel, 0);
        chk("rd_busy_low", busy, 0);
        chk("rd_done_cnt", done_cnt - d0, 1);

        // zero-length load
        w0 = wlog_adr.size();
        start_load(12'h050, 13'd0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_done_low", done, 0);
        chk("len0_nowen", wlog_adr.size() - w0, 0);

        // rd_start while loading is ignored
        w0 = wlog_adr.size(); s0 = sel_cnt;
        start_load(12'h030, 13'd1);
        rd_adr = 12'h000; rd_len = 13'd1; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(tail[i]);
        wait_done("ign_done");
        tick();
        chk("ign_nwrites", wlog_adr.size() - w0, 1);
        chk("ign_sel", sel_cnt - s0, 0);
        chk("ign_vld", out_vld, 0);

        // stray byte sets byte_err, next ld_start clears it
        send_byte(8'h5A);
        chk("err_set", byte_err, 1);
        tick();
        chk("err_sticky", byte_err, 1);
        start_load(12'h000, 13'd0);
        chk("err_clr", byte_err, 0);
        tick();

        // run pulse
        p0 = pc_cnt; d0 = done_cnt;
        run_adr = 30'h0000_0040; run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("run_pc", pc_start, 1);
        chk("run_adr", start_adr, 32'h40);
        chk("run_busy", busy, 1);
        tick();
        chk("run_pc_low", pc_start, 0);
        chk("run_done", done, 1);
        tick();
        chk("run_adr_hold", start_adr, 32'h40);
        chk("run_pc_cnt", pc_cnt - p0, 1);
        chk("run_done_cnt", done_cnt - d0, 1);

        // reset mid-load discards the partial word
        w0 = wlog_adr.size(); d0 = done_cnt;
        start_load(12'h020, 13'd1);
        for (int i = 0; i < 3; i++) send_byte(tail[i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("rstm_busy", busy, 0);
        chk("rstm_outs", {out_vld, i_ram_wen, i_read_sel, pc_start, done}, 0);
        chk("rstm_start_adr", start_adr, 0);
        chk("rstm_nowen", wlog_adr.size() - w0, 0);
        chk("rstm_nodone", done_cnt - d0, 0);
        start_load(12'h020, 13'd1);
        for (int i = 0; i < 4; i++) send_byte(tail[i]);
        wait_done("rstm_done");
        tick();
        chk("rstm_nwrites", wlog_adr.size() - w0, 1);
        if (wlog_adr.size() - w0 == 1) begin
            chk("rstm_adr", wlog_adr[w0], 32'h020);
            chk("rstm_dat", wlog_dat[w0], 32'hDDCC_BBAA);
        end

        chk("exclusive_wen", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
